alm_mult_arbiter: RTL
=====================

# alm_mult_arbiter

Round-robin arbiter and 2-stage pipeline controller that shares one combinational `ALM_Gen_multiplication_unit` among `NREQ` requesters. Each requester presents log-format operands (`{k, fraction}`) plus zero flags. The block grants one request per cycle, registers the operands into the shared multiplier, and captures the product. It returns the product with the requester's ID through a valid/ready response port that supports backpressure. It sits between the processing-element operand converters (LOD/BLC front end) and the accumulators.

## Interface
Parameters:
- `A_BW`, default 16: operand A width. Must equal `B_BW`.
- `B_BW`, default 16: operand B width.
- `NREQ`, default 4: number of requesters, 2..16.
- `M`, default 6: passed through to the multiplier instance.
- Derived widths:
  - `LW = $clog2(A_BW)+A_BW-1` (log-format width).
  - `IDW = $clog2(NREQ)`.
  - `PW = A_BW+B_BW`.

Ports:
- `clk` in 1: the only clock. All state is updated on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept. At most one bit is high in any cycle.
- `req_log_a` in NREQ*LW: A operands, requester i in bits `[i*LW +: LW]`.
- `req_a_zero` in NREQ: A zero flags.
- `req_log_b` in NREQ*LW: B operands, same packing as `req_log_a`.
- `req_b_zero` in NREQ: B zero flags.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out IDW: requester index of the response.
- `rsp_product` out PW: product.

## Operation
- The multiplier instance is internal. Its inputs are driven only from stage-1 registers.
- Stage 1 (S1) holds `s1_valid`, `s1_id`, `s1_log_a`, `s1_a_zero`, `s1_log_b`, `s1_b_zero`.
- Stage 2 (S2) holds `rsp_valid`, `rsp_id`, `rsp_product`.
- Advance conditions:
  - `s2_free = !rsp_valid | rsp_ready`.
  - `s1_free = !s1_valid | s2_free`.
- Arbitration:
  - Search `req_valid` starting at index `rr_ptr` and wrapping modulo NREQ; the first set bit wins, giving a one-hot `grant`.
  - `req_ready = grant & {NREQ{s1_free}}`.
  - `req_ready[i]` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Accept: when `req_valid[i] & req_ready[i]`, S1 loads requester i's operands and `s1_id = i`, and `rr_ptr` becomes `(i+1) mod NREQ`.
- Without an accept, `rr_ptr` holds.
- S1 to S2: when `s1_valid & s2_free`, `rsp_product` loads the multiplier output and `rsp_id` loads `s1_id`. The multiplier already forces the product to 0 when either zero flag is set.
- `s1_valid` is updated as follows:
  - Set by an accept.
  - Otherwise cleared when S1 moves to S2.
- `rsp_valid` is updated as follows:
  - Set when S1 moves to S2.
  - Otherwise cleared when `rsp_ready` is high.
- Simultaneous accept and move: both occur in the same cycle, giving full throughput of one product per cycle.
- Stall: while `rsp_valid & !rsp_ready`:
  - S2 holds and `rsp_*` stays stable.
  - S1 holds if valid.
  - With S1 full, `req_ready` is all zero.
- A request not granted may keep `req_valid` high. Its operands must stay stable until accepted.
- No request is ever dropped or duplicated. Responses leave in acceptance order.

## Timing
- Reset (`rst_n` low at a rising edge) sets:
  - `s1_valid`, `rsp_valid` and all datapath registers to 0.
  - `rsp_id` and `rsp_product` to 0.
  - `rr_ptr` to 0.
- While `rst_n` is low, `req_ready` is forced to 0.
- Reset mid-operation discards in-flight S1/S2 contents without emitting them.
- Latency: a request accepted at edge N is presented on `rsp_*` after edge N+1, provided S2 was free.
- Throughput: 1 accept per cycle when `rsp_ready` is held high.
- Fairness: with all NREQ valid continuously and no stall, the grant order is `rr_ptr`, `rr_ptr+1`, ... modulo NREQ. No requester waits more than NREQ-1 accepts.
- The critical path is from the S1 registers through the multiplier to the S2 registers. Arbitration logic is not on that path.

## Configuration
- Macro: `ALM_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority, lowest index wins. `rr_ptr` is removed and the search always starts at 0.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request, default parameters:
  - Stimulus: requester 2 sends A=4 (`k=2`, fraction 0) and B=8 (`k=3`, fraction 0). `rsp_ready` is held high.
  - Response: `req_ready[2]` high in the accept cycle; after the next edge, `rsp_valid=1`, `rsp_id=2`, `rsp_product=32`.
- Zero flag:
  - Stimulus: requester 0 sends A=4, B=8 with `req_b_zero=1`.
  - Response: `rsp_product=0`, `rsp_id=0`.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid for 8 cycles with no stall.
  - Response: `rsp_id` sequence 0,1,2,3,0,1,2,3; one response per cycle after the first.
- Backpressure:
  - Stimulus: 3 requests back-to-back, with `rsp_ready=0` for 5 cycles.
  - Response: `rsp_*` stable during the stall; `req_ready` goes to zero once S1 fills; after release, all 3 responses arrive in order with none lost.
- Reset mid-flight:
  - Stimulus: `rst_n` low for 1 cycle while S1 and S2 are both valid.
  - Response: next cycle `rsp_valid=0`, `rsp_product=0`; the next grant goes to requester 0.
- With `ALM_ARB_FIXED_PRIO_EN` defined:
  - Stimulus: requesters 1 and 3 held valid continuously.
  - Response: only requester 1 is granted until it drops `req_valid`.

Source files
------------

// File: rtl/alm_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ALM_Gen_multiplication_unit
//  Description : Combinational approximate log-domain (Mitchell-style)
//                multiplier. Each operand is {k, fraction}, where k is the
//                leading-one position and fraction holds the bits below the
//                leading one, MSB-aligned. Only the top M fraction bits of each
//                operand are used. The product is
//                2^(ka+kb) * (1 + fa + fb)   when fa + fb < 1
//                2^(ka+kb+1) * (fa + fb)     otherwise
//                and it is forced to 0 when either zero flag is set.
//  Ports       : i_log_a/i_log_b   log-format operands
//                i_a_zero/i_b_zero operand-is-zero flags
//                o_product         A_BW+B_BW bit product
//  Revision    : 1.0  initial release
// ============================================================================
module ALM_Gen_multiplication_unit #(
    parameter int A_BW = 16,
    parameter int B_BW = 16,
    parameter int M    = 6
) (
    input  logic [$clog2(A_BW)+A_BW-2:0] i_log_a,
    input  logic                         i_a_zero,
    input  logic [$clog2(A_BW)+A_BW-2:0] i_log_b,
    input  logic                         i_b_zero,
    output logic [A_BW+B_BW-1:0]         o_product
);
    localparam int KW = $clog2(A_BW);
    localparam int FW = A_BW - 1;
    localparam int LW = KW + FW;
    localparam int MT = (M < FW) ? M : FW;   // fraction bits actually used
    localparam int PW = A_BW + B_BW;

    logic [KW-1:0]    w_ka;
    logic [KW-1:0]    w_kb;
    logic [MT-1:0]    w_fa;
    logic [MT-1:0]    w_fb;
    logic [MT:0]      w_fsum;
    logic [KW:0]      w_exp;
    logic [MT:0]      w_mant;
    logic [PW+MT-1:0] w_wide;
    logic             w_unused_lsbs;

    assign w_ka   = i_log_a[LW-1 -: KW];
    assign w_kb   = i_log_b[LW-1 -: KW];
    assign w_fa   = i_log_a[FW-1 -: MT];
    assign w_fb   = i_log_b[FW-1 -: MT];

    // Fraction carry-out moves the result into the next binade; the mantissa
    // is then 1.(fa+fb-1), which has the same bit pattern as the sum's LSBs.
    assign w_fsum = {1'b0, w_fa} + {1'b0, w_fb};
    assign w_exp  = {1'b0, w_ka} + {1'b0, w_kb} + {{KW{1'b0}}, w_fsum[MT]};
    assign w_mant = {1'b1, w_fsum[MT-1:0]};
    assign w_wide = {{(PW-1){1'b0}}, w_mant} << w_exp;

    assign o_product = (i_a_zero | i_b_zero) ? '0 : w_wide[PW+MT-1:MT];

    // Truncated fraction LSBs intentionally do not contribute.
    assign w_unused_lsbs = ^{i_log_a, i_log_b};
endmodule

// ============================================================================
//  Module      : alm_mult_arbiter
//  Description : Round-robin arbiter feeding one shared ALM multiplier through
//                a 2-stage pipeline (S1 operand registers, S2 product/response
//                registers) with a valid/ready response port.
//  Build macro : ALM_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest
//                index wins) replaces round-robin and the pointer is removed.
//  Ports       : clk, rst_n (synchronous, active low)
//                req_valid/req_ready       per-requester handshake
//                req_log_a/req_log_b       packed operands, i at [i*LW +: LW]
//                req_a_zero/req_b_zero     per-requester zero flags
//                rsp_valid/rsp_ready       response handshake
//                rsp_id/rsp_product        requester index and product
//  Revision    : 1.0  initial release
// ============================================================================
module alm_mult_arbiter #(
    parameter int A_BW = 16,
    parameter int B_BW = 16,
    parameter int NREQ = 4,
    parameter int M    = 6,
    localparam int LW  = $clog2(A_BW) + A_BW - 1,
    localparam int IDW = $clog2(NREQ),
    localparam int PW  = A_BW + B_BW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*LW-1:0] req_log_a,
    input  logic [NREQ-1:0]    req_a_zero,
    input  logic [NREQ*LW-1:0] req_log_b,
    input  logic [NREQ-1:0]    req_b_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [PW-1:0]      rsp_product
);
    // Stage 1 registers
    logic           r_s1_valid;
    logic [IDW-1:0] r_s1_id;
    logic [LW-1:0]  r_s1_log_a;
    logic           r_s1_a_zero;
    logic [LW-1:0]  r_s1_log_b;
    logic           r_s1_b_zero;

    // Stage 2 registers
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [PW-1:0]  r_rsp_product;

    logic           w_s2_free;
    logic           w_s1_free;
    logic [IDW-1:0] w_start;
    logic [IDW:0]   w_idx;
    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_id;
    logic [NREQ-1:0] w_grant;
    logic           w_accept;
    logic           w_move;
    logic [PW-1:0]  w_mult_product;

`ifdef ALM_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [IDW-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`endif

    assign w_s2_free = ~r_rsp_valid | rsp_ready;
    assign w_s1_free = ~r_s1_valid | w_s2_free;

    // Circular search from w_start; the index is kept one bit wider so the
    // wrap can be done with a single conditional subtract for any NREQ.
    always_comb begin
        w_idx     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx = {1'b0, w_start} + (IDW+1)'(off);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_gnt_any && req_valid[w_idx[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_idx[IDW-1:0];
            end
        end
    end

    assign w_grant   = w_gnt_any ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign req_ready = w_grant & {NREQ{w_s1_free & rst_n}};
    assign w_accept  = w_gnt_any & w_s1_free & rst_n;
    assign w_move    = r_s1_valid & w_s2_free;

    ALM_Gen_multiplication_unit #(
        .A_BW (A_BW),
        .B_BW (B_BW),
        .M    (M)
    ) u_mult (
        .i_log_a   (r_s1_log_a),
        .i_a_zero  (r_s1_a_zero),
        .i_log_b   (r_s1_log_b),
        .i_b_zero  (r_s1_b_zero),
        .o_product (w_mult_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_id       <= '0;
            r_s1_log_a    <= '0;
            r_s1_a_zero   <= 1'b0;
            r_s1_log_b    <= '0;
            r_s1_b_zero   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid  <= 1'b1;
                r_s1_id     <= w_gnt_id;
                r_s1_log_a  <= req_log_a[w_gnt_id*LW +: LW];
                r_s1_a_zero <= req_a_zero[w_gnt_id];
                r_s1_log_b  <= req_log_b[w_gnt_id*LW +: LW];
                r_s1_b_zero <= req_b_zero[w_gnt_id];
            end else if (w_move) begin
                r_s1_valid  <= 1'b0;
            end

            if (w_move) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_id      <= r_s1_id;
                r_rsp_product <= w_mult_product;
            end else if (rsp_ready) begin
                r_rsp_valid   <= 1'b0;
            end
        end
    end

`ifndef ALM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
        end
    end
`endif

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
endmodule
`default_nettype wire
